// File: rtl/detector_rx.sv
// Detector receive front end: frame-aligned pixel capture into a packetised
// valid/ready stream with sop/eop markers, frame geometry and sticky overflow.
module detector_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  det_fval,
  input  logic                  det_lval,
  input  logic [DATA_WIDTH-1:0] det_data,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sop,
  output logic                  dout_eop,
  output logic [CNT_WIDTH-1:0]  frame_width,
  output logic [CNT_WIDTH-1:0]  frame_height,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {WAIT_GAP, WAIT_FRAME, IN_FRAME} state_t;

  state_t state, state_nxt;
  logic   sample, enter, fval_fall;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_GAP;
    else     state <= state_nxt;
  end

  // WAIT_GAP refuses to lock on until a frame gap is seen, so a partial frame
  // in flight at reset release is never captured.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    enter     = 1'b0;
    fval_fall = 1'b0;
    case (state)
      WAIT_GAP: begin
        if (!det_fval) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (det_fval) begin
          state_nxt = IN_FRAME;
          enter     = 1'b1;
          sample    = det_lval;
        end
      end
      IN_FRAME: begin
        if (!det_fval) begin
          state_nxt = WAIT_FRAME;
          fval_fall = 1'b1;
        end else begin
          sample = det_lval;
        end
      end
      default: state_nxt = WAIT_GAP;
    endcase
  end

  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_sop, hold_valid, got_pix, lval_q;
  logic                  push, push_eop;

  assign push     = hold_valid & (sample | fval_fall);
  assign push_eop = fval_fall;

  // The held pixel is only released once we know whether it ends the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= '0;
      hold_sop   <= 1'b0;
      hold_valid <= 1'b0;
      got_pix    <= 1'b0;
      lval_q     <= 1'b0;
    end else begin
      lval_q <= det_lval;
      if (sample) begin
        hold_data  <= det_data;
        hold_sop   <= enter | ~got_pix;
        hold_valid <= 1'b1;
      end else if (fval_fall) begin
        hold_valid <= 1'b0;
      end
      if (enter)       got_pix <= sample;
      else if (sample) got_pix <= 1'b1;
    end
  end

  logic [CNT_WIDTH-1:0] pix_cnt, lin_cnt;
  logic                 lin_fall;

  assign lin_fall = (state == IN_FRAME) & det_fval & lval_q & ~det_lval;

  // pix_cnt only runs while no line has closed yet, i.e. during the first line.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt      <= '0;
      lin_cnt      <= '0;
      frame_width  <= '0;
      frame_height <= '0;
    end else if (enter) begin
      pix_cnt <= sample ? CNT_WIDTH'(1) : '0;
      lin_cnt <= '0;
    end else if (state == IN_FRAME) begin
      if (fval_fall) begin
        frame_width <= pix_cnt;
        if (lval_q && lin_cnt != CNT_MAX) frame_height <= lin_cnt + 1'b1;
        else                              frame_height <= lin_cnt;
      end else begin
        if (sample && lin_cnt == '0 && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
        if (lin_fall && lin_cnt != CNT_MAX)                lin_cnt <= lin_cnt + 1'b1;
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          empty, full, pop, wr_en, ovf_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & dout_ready;
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {hold_data, hold_sop, push_eop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  // Outputs are gated by valid so stale memory never shows after reset.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign dout_valid = ~empty;
  assign dout_data  = dout_valid ? head[EW-1:2] : '0;
  assign dout_sop   = dout_valid & head[1];
  assign dout_eop   = dout_valid & head[0];

endmodule

// File: tb/tb_detector_rx.sv
// Self-checking bench for detector_rx: table of frame shapes plus directed
// sequences for reset, backpressure, overflow and back-to-back frames.
module tb_detector_rx;

  localparam int DW = 16;
  localparam int CW = 12;

  logic          clk, rst;
  logic          det_fval, det_lval;
  logic [DW-1:0] det_data;
  logic [DW-1:0] dout_data;
  logic          dout_valid, dout_ready, dout_sop, dout_eop;
  logic [CW-1:0] frame_width, frame_height;
  logic          ovf, ovf_clr;

  int errors = 0;
  int checks = 0;

  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];

  typedef struct {
    int lines;
    int ppl;
    int gap;
    int base;
    bit lval_hold;
    int lead;
    int exp_w;
    int exp_h;
    int exp_beats;
  } frame_vec_t;

  frame_vec_t vecs[5];

  detector_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .det_fval(det_fval), .det_lval(det_lval), .det_data(det_data),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .frame_width(frame_width), .frame_height(frame_height),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready)
      got_q.push_back({dout_data, dout_sop, dout_eop});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int data, input bit sop, input bit eop);
    exp_q.push_back({DW'(data), sop, eop});
  endtask

  task automatic build_frame_exp(input int base, input int n);
    for (int i = 0; i < n; i++) push_exp(base + i, i == 0, i == n - 1);
  endtask

  task automatic check_output(input string name);
    check_val({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s_beat%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_geom(input string name, input int w, input int h);
    check_val({name, "_width"},  32'(frame_width),  32'(w));
    check_val({name, "_height"}, 32'(frame_height), 32'(h));
  endtask

  task automatic apply_stimulus(input int lines, input int ppl, input int gap, input int base,
                                input bit lval_hold, input int lead, input int tail);
    int d;
    d = base;
    det_fval = 1'b1;
    det_lval = 1'b0;
    det_data = 16'hDEAD;
    repeat (lead) tick();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        det_lval = 1'b1;
        det_data = DW'(d);
        d++;
        tick();
      end
      if (!(lval_hold && l == lines - 1)) begin
        det_lval = 1'b0;
        det_data = 16'hDEAD;
        repeat (gap) tick();
      end
    end
    det_fval = 1'b0;
    tick();
    det_lval = 1'b0;
    det_data = 16'hDEAD;
    repeat (tail - 1) tick();
  endtask

  initial begin
    vecs[0] = '{lines: 3, ppl: 4, gap: 2, base: 'h0000, lval_hold: 0, lead: 1, exp_w: 4, exp_h: 3, exp_beats: 12};
    vecs[1] = '{lines: 1, ppl: 1, gap: 0, base: 'hABCD, lval_hold: 1, lead: 1, exp_w: 1, exp_h: 1, exp_beats: 1};
    vecs[2] = '{lines: 2, ppl: 2, gap: 1, base: 'h0100, lval_hold: 0, lead: 1, exp_w: 2, exp_h: 2, exp_beats: 4};
    vecs[3] = '{lines: 2, ppl: 5, gap: 3, base: 'h0200, lval_hold: 0, lead: 0, exp_w: 5, exp_h: 2, exp_beats: 10};
    vecs[4] = '{lines: 0, ppl: 0, gap: 0, base: 'h0000, lval_hold: 0, lead: 3, exp_w: 0, exp_h: 0, exp_beats: 0};

    rst = 1'b1;
    det_fval = 1'b0;
    det_lval = 1'b0;
    det_data = '0;
    dout_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", 32'(dout_valid), 32'd0);
    check_val("rst_sop",   32'(dout_sop),   32'd0);
    check_val("rst_eop",   32'(dout_eop),   32'd0);
    check_val("rst_data",  32'(dout_data),  32'd0);
    check_val("rst_ovf",   32'(ovf),        32'd0);
    check_geom("rst", 0, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      apply_stimulus(vecs[v].lines, vecs[v].ppl, vecs[v].gap, vecs[v].base,
                     vecs[v].lval_hold, vecs[v].lead, 2);
      check_geom($sformatf("vec%0d", v), vecs[v].exp_w, vecs[v].exp_h);
      repeat (4) tick();
      build_frame_exp(vecs[v].base, vecs[v].exp_beats);
      check_output($sformatf("vec%0d", v));
      check_val($sformatf("vec%0d_ovf", v), 32'(ovf), 32'd0);
    end

    $display("[TB] backpressure");
    dout_ready = 1'b0;
    apply_stimulus(1, 8, 1, 'h300, 0, 1, 2);
    check_val("bp_valid", 32'(dout_valid), 32'd1);
    check_val("bp_data0", 32'(dout_data),  32'h300);
    check_val("bp_sop",   32'(dout_sop),   32'd1);
    repeat (3) tick();
    check_val("bp_data_stable", 32'(dout_data), 32'h300);
    check_geom("bp", 8, 1);
    dout_ready = 1'b1;
    repeat (12) tick();
    build_frame_exp('h300, 8);
    check_output("bp");
    check_val("bp_ovf", 32'(ovf), 32'd0);

    $display("[TB] overflow");
    dout_ready = 1'b0;
    apply_stimulus(1, 20, 1, 'h400, 0, 1, 2);
    check_val("ovf_set", 32'(ovf), 32'd1);
    dout_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 16; i++) push_exp('h400 + i, i == 0, 1'b0);
    check_output("ovf");
    check_val("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_clr", 32'(ovf), 32'd0);

    $display("[TB] mid-frame reset");
    got_q.delete();
    dout_ready = 1'b0;
    det_fval = 1'b1;
    det_lval = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      det_lval = 1'b1;
      det_data = DW'('h50 + i);
      tick();
    end
    check_val("mrst_pre_valid", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    for (int i = 3; i < 5; i++) begin
      det_data = DW'('h50 + i);
      tick();
    end
    check_val("mrst_valid", 32'(dout_valid), 32'd0);
    check_val("mrst_width", 32'(frame_width), 32'd0);
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 5; i < 9; i++) begin
      det_data = DW'('h50 + i);
      tick();
    end
    det_lval = 1'b0;
    tick();
    det_fval = 1'b0;
    repeat (5) tick();
    check_val("mrst_no_output", 32'(got_q.size()), 32'd0);
    check_geom("mrst_orphan", 0, 0);
    apply_stimulus(1, 3, 1, 'h60, 0, 1, 2);
    check_geom("mrst_next", 3, 1);
    repeat (4) tick();
    build_frame_exp('h60, 3);
    check_output("mrst_next");

    $display("[TB] back-to-back");
    got_q.delete();
    apply_stimulus(2, 2, 1, 'h500, 0, 1, 1);
    check_geom("b2b_a", 2, 2);
    apply_stimulus(2, 2, 1, 'h600, 0, 1, 3);
    check_geom("b2b_b", 2, 2);
    repeat (4) tick();
    build_frame_exp('h500, 4);
    build_frame_exp('h600, 4);
    check_output("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detector_rx.md
# detector_rx

Receive-side front end for the detector interface. It samples the detector's parallel pixel bus, qualified by frame-valid and line-valid, and aligns capture to frame boundaries. Pixels are converted into a packetised valid/ready stream with start-of-frame and end-of-frame markers, buffered through a small FIFO. It sits between the detector pins (after any fixed-delay alignment stages) and the downstream video pipeline. It also reports measured frame geometry and a sticky overflow flag.

## Interface
- DATA_WIDTH, 16, pixel width in bits
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2, at least 4
- CNT_WIDTH, 12, width of the geometry counters

Ports:
- clk  in  1  single clock; detector bus is synchronous to it
- rst  in  1  reset, synchronous and active-high
- det_fval  in  1  frame valid from detector
- det_lval  in  1  line valid from detector
- det_data  in  DATA_WIDTH  pixel data; valid when det_fval and det_lval are both high
- dout_data  out  DATA_WIDTH  output pixel
- dout_valid  out  1  output pixel valid
- dout_ready  in  1  downstream accepts
- dout_sop  out  1  first pixel of frame, qualified by dout_valid
- dout_eop  out  1  last pixel of frame, qualified by dout_valid
- frame_width  out  CNT_WIDTH  pixels in the first line of the last completed frame
- frame_height  out  CNT_WIDTH  lines in the last completed frame
- ovf  out  1  sticky FIFO overflow
- ovf_clr  in  1  clears ovf

## Operation
- **FSM states:** WAIT_GAP, WAIT_FRAME, IN_FRAME. Reset state is WAIT_GAP.
  - WAIT_GAP -> WAIT_FRAME when det_fval=0 is sampled. This discards any frame already in progress at reset release.
  - WAIT_FRAME -> IN_FRAME when det_fval=1 is sampled.
  - IN_FRAME -> WAIT_FRAME when det_fval=0 is sampled.
- **Pixel sampling:** a pixel is sampled in IN_FRAME, and on the WAIT_FRAME->IN_FRAME edge, whenever det_fval&det_lval=1.
- **One-pixel hold register:** holds the pending pixel plus its sop bit, with a hold_valid flag.
  - A new sampled pixel pushes the held pixel to the FIFO with eop=0, then loads itself.
  - det_fval=0 sampled while hold_valid=1 pushes the held pixel with eop=1 and clears hold_valid.
  - sop=1 for the first sampled pixel after entering IN_FRAME.
- **FIFO:** show-ahead, entries of DATA_WIDTH+2 bits (data, sop, eop).
  - dout_valid = FIFO not empty.
  - A pop occurs when dout_valid & dout_ready.
- **Overflow:** a push while the FIFO is full (and no simultaneous pop) discards the entry and sets ovf.
  - A push and pop in the same cycle on a full FIFO is legal and does not overflow.
  - ovf holds until ovf_clr or rst. If ovf_clr and a new overflow occur in the same cycle, ovf stays set.
- **Geometry counters:**
  - pix_cnt counts sampled pixels of the first line. lin_cnt counts lval falling edges inside the frame, plus 1 if lval is high when fval falls.
  - Both counters saturate at all-ones.
  - On IN_FRAME exit, frame_width and frame_height load from the counters. Internal counters clear on entry to IN_FRAME.
  - A frame with zero pixels updates the geometry to 0/0 and produces no stream output.
- **Reset behaviour:** rst clears the FSM, hold register, FIFO pointers, counters and ovf. Reset mid-frame drops all buffered pixels; no eop is emitted for that frame.
- **Reset values:** dout_valid=0, dout_sop=0, dout_eop=0, dout_data=0, frame_width=0, frame_height=0, ovf=0.

## Timing
- All inputs are sampled on the rising edge of clk. There is no input register.
- **FIFO write timing:**
  - Pixel P(n), sampled at edge e, is written to the FIFO at the edge where P(n+1) is sampled.
  - The last pixel is written at the edge where det_fval=0 is sampled.
- **Output timing:** dout_valid rises in the cycle after the FIFO write (write-to-read latency 1).
  - Contiguous line: P0 sampled at e0, P1 at e0+1. P0 is written at e0+1 and presented after e0+1.
- **Throughput:** 1 pixel/clk sustained when dout_ready=1.
- **Geometry update:** frame_width and frame_height update at the edge where det_fval=0 is sampled in IN_FRAME.

## Test plan
1. **Basic frame:** reset, then det_fval low for 2 cycles, then a frame of 3 lines x 4 pixels (data 0..11), 2-cycle lval gaps, dout_ready=1.
   - Expect 12 beats with data 0..11 in order.
   - sop only on 0; eop only on 11.
   - frame_width=4, frame_height=3, ovf=0.
2. **Mid-frame reset release:** rst deasserted while det_fval=1 with pixels flowing.
   - Expect no output until fval has gone low and the next frame starts.
   - The first output beat has sop=1.
3. **Backpressure:** dout_ready=0 throughout a 1x8 frame with FIFO_DEPTH=16.
   - Expect all 8 beats to be retained and dout_data to stay stable.
   - Release ready: 8 beats in order, eop on the last beat, ovf=0.
4. **Overflow:** dout_ready=0 for a 1x20 frame with FIFO_DEPTH=16.
   - Expect ovf=1 and 16 beats delivered (pixels 0..15). The eop of the dropped tail is lost.
   - Pulse ovf_clr: ovf=0 on the next cycle.
5. **Single-pixel frame and lval held high at fval fall:** 1x1 frame (data 0xABCD) with lval high when fval falls.
   - Expect one beat with sop=1, eop=1.
   - frame_width=1, frame_height=1.
6. **Back-to-back frames with a 1-cycle fval gap:** two 2x2 frames.
   - Expect 8 beats, with sop and eop marking each frame correctly.
   - Geometry reads 2/2 after each frame.
